fix_frame_ctrl: RTL and testbench
=================================

Name: fix_frame_ctrl

Overview:
Byte-level framing controller for inbound FIX messages. It finds the "8=" start of a message, tracks the byte stream up to the "10=" trailer tag, and keeps the modulo-256 checksum over the covered bytes. It then decodes the three ASCII checksum digits, compares them with the computed value and reports one pass/fail result per message. It sits between the receive byte stream and the field parser and gates which messages are forwarded.

Parameters:
MAX_LEN, 1024, maximum counted bytes per message ('8' through the SOH before "10="); exceeding it aborts the message
LEN_W, 11, width of the internal length counter; must hold MAX_LEN+1

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
data_i  input  8  received byte
valid_i  input  1  data_i valid
ready_o  output  1  byte accepted when valid_i && ready_o
busy_o  output  1  high in any state other than IDLE
msg_done_o  output  1  one-cycle pulse: result fields valid
msg_ok_o  output  1  qualified by msg_done_o: checksum matched, no error
err_o  output  2  qualified by msg_done_o: 0 none, 1 mismatch, 2 bad trailer format, 3 length overflow
calc_cksum_o  output  8  computed checksum, held until next msg_done_o
rx_cksum_o  output  10  decoded received value 0..999, held until next msg_done_o

Behaviour:
- Reset: state IDLE; all outputs 0 except ready_o=1; sum, snapshot, length, digit count and rx value cleared. Reset mid-message discards the message with no msg_done_o.
- Only accepted bytes (valid_i && ready_o) advance state. Idle cycles (valid_i=0) hold all state.
- ready_o=1 in every state except REPORT.
- Accumulation: sum <= sum + byte, 8-bit wrap. Applies to every accepted byte from '8' onward while in GOT8, BODY, AFT_SOH, T1 or T10. Length increments on the same bytes.
- Snapshot: on every accepted SOH (0x01) in BODY/AFT_SOH/T1/T10, snap <= sum + 0x01 and len_snap <= length+1. The trailer bytes "10=" are therefore excluded from the checksum.
- IDLE: '8' (0x38) -> GOT8, sum=0x38, length=1. Any other byte is dropped.
- GOT8: '=' (0x3D) -> BODY, accumulated. '8' -> stays in GOT8, sum=0x38, length=1. Any other byte -> IDLE.
- BODY: SOH -> AFT_SOH. Any other byte -> BODY.
- AFT_SOH: '1' -> T1. SOH -> AFT_SOH. Any other byte -> BODY.
- T1: '0' -> T10. SOH -> AFT_SOH. Any other byte -> BODY.
- T10: '=' -> DIG, with digit count=0 and rx=0. SOH -> AFT_SOH. Any other byte -> BODY.
- DIG: '0'..'9' gives rx <= rx*10 + (byte-0x30) and count++. After the third digit -> TERM. A non-digit -> REPORT with err=2.
- TERM: SOH -> REPORT. err=1 if rx != snap, else err=0. Any other byte -> REPORT with err=2.
- Overflow: if an accepted byte would make length exceed MAX_LEN while in GOT8/BODY/AFT_SOH/T1/T10 -> REPORT with err=3. That byte is consumed.
- REPORT: lasts one cycle. msg_done_o=1, ready_o=0, msg_ok_o=(err==0), calc_cksum_o=snap (0 on err=3), rx_cksum_o=rx. Next cycle -> IDLE.
- Latency: msg_done_o is asserted in the cycle after the terminating byte is accepted.
- Received values above 255 (e.g. "999") decode normally and report err=1.
- A "10=" sequence that is not preceded by SOH is body data and causes no trailer detection.

Test Plan:
- Minimal frame "8=A",01,"10=183",01 -> msg_done_o one cycle after final SOH, msg_ok_o=1, err=0, calc=0xB7, rx=183.
- Same frame with trailer "10=184" -> msg_ok_o=0, err=1, calc=0xB7, rx=184.
- Decoy tag "8=A",01,"11=B",01,"10=153",01 -> "11=" does not trigger the trailer; ok, calc=153.
- Bad trailer "8=A",01,"10=1x" -> msg_done_o after 'x' with err=2. A following valid frame is then accepted with no leftover state.
- MAX_LEN=8: "8=ABCDEFG" -> err=3 on the 9th byte, calc=0. Trailing garbage before the next '8' is ignored.
- Minimal frame with valid_i toggling every other cycle, and rst asserted mid-body on a second frame -> first frame ok. After the reset: no msg_done_o, outputs 0, busy_o=0.

Source files
------------

// File: rtl/fix_frame_ctrl_if.sv
// rtl/fix_frame_ctrl_if.sv - byte stream and per-message result bundle for fix_frame_ctrl
interface fix_frame_ctrl_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       busy_o;
    logic       msg_done_o;
    logic       msg_ok_o;
    logic [1:0] err_o;
    logic [7:0] calc_cksum_o;
    logic [9:0] rx_cksum_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, busy_o, msg_done_o, msg_ok_o, err_o, calc_cksum_o, rx_cksum_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, busy_o, msg_done_o, msg_ok_o, err_o, calc_cksum_o, rx_cksum_o
    );
endinterface

// File: rtl/fix_frame_ctrl.sv
// rtl/fix_frame_ctrl.sv - FIX message framing, modulo-256 checksum and trailer verification
module fix_frame_ctrl #(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 11
) (
    input  logic            clk,
    input  logic            rst,
    fix_frame_ctrl_if.slave bus
);
    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] CH_8  = 8'h38;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_0  = 8'h30;

    typedef enum logic [3:0] {
        IDLE, GOT8, BODY, AFT_SOH, T1, T10, DIG, TERM, REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sum_q, sum_d, snap_q, snap_d, calc_q, calc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       cnt_q, cnt_d, err_q, err_d;
    logic [9:0]       rx_q, rx_d, rx_out_q, rx_out_d;
    logic [7:0]       d;
    logic             accept, is_digit;

    assign d        = bus.data_i;
    assign accept   = bus.valid_i && bus.ready_o;
    assign is_digit = (d >= 8'h30) && (d <= 8'h39);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            snap_q   <= '0;
            calc_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            rx_q     <= '0;
            rx_out_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            snap_q   <= snap_d;
            calc_q   <= calc_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rx_q     <= rx_d;
            rx_out_q <= rx_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        snap_d   = snap_q;
        calc_d   = calc_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rx_d     = rx_q;
        rx_out_d = rx_out_q;
        if (state_q == REPORT) begin
            state_d = IDLE;
        end else if (accept) begin
            if (state_q == IDLE) begin
                if (d == CH_8) begin
                    state_d = GOT8;
                    sum_d   = CH_8;
                    len_d   = LEN_W'(1);
                end
            end else if (state_q == DIG) begin
                if (is_digit) begin
                    rx_d  = rx_q * 10'd10 + {6'd0, d[3:0]};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd2) state_d = TERM;
                end else begin
                    state_d  = REPORT;
                    err_d    = 2'd2;
                    calc_d   = snap_q;
                    rx_out_d = rx_q;
                end
            end else if (state_q == TERM) begin
                state_d  = REPORT;
                calc_d   = snap_q;
                rx_out_d = rx_q;
                if (d != SOH)                    err_d = 2'd2;
                else if (rx_q != {2'b00, snap_q}) err_d = 2'd1;
                else                             err_d = 2'd0;
            end else if (len_q >= LEN_W'(MAX_LEN)) begin
                // Counting states only from here on: the overflowing byte is consumed.
                state_d  = REPORT;
                err_d    = 2'd3;
                calc_d   = '0;
                rx_out_d = rx_q;
            end else begin
                sum_d = sum_q + d;
                len_d = len_q + LEN_W'(1);
                // Snapshot through each SOH so "10=" never enters the checked sum.
                if (d == SOH && state_q != GOT8) snap_d = sum_q + SOH;
                case (state_q)
                    GOT8: begin
                        if (d == CH_EQ) begin
                            state_d = BODY;
                        end else if (d == CH_8) begin
                            sum_d = CH_8;
                            len_d = LEN_W'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    AFT_SOH: state_d = (d == CH_1) ? T1  : (d == SOH) ? AFT_SOH : BODY;
                    T1:      state_d = (d == CH_0) ? T10 : (d == SOH) ? AFT_SOH : BODY;
                    T10: begin
                        if (d == CH_EQ) begin
                            state_d = DIG;
                            cnt_d   = '0;
                            rx_d    = '0;
                        end else begin
                            state_d = (d == SOH) ? AFT_SOH : BODY;
                        end
                    end
                    default: state_d = (d == SOH) ? AFT_SOH : BODY;
                endcase
            end
        end
    end

    assign bus.ready_o      = (state_q != REPORT);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.msg_done_o   = (state_q == REPORT);
    assign bus.msg_ok_o     = (state_q == REPORT) && (err_q == 2'd0);
    assign bus.err_o        = err_q;
    assign bus.calc_cksum_o = calc_q;
    assign bus.rx_cksum_o   = rx_out_q;
endmodule

// File: tb/tb_fix_frame_ctrl.sv
// tb/tb_fix_frame_ctrl.sv - self-checking bench for fix_frame_ctrl (MAX_LEN 1024 and 8 instances)
module tb_fix_frame_ctrl;
    logic clk;
    logic rst;

    logic [7:0]      drv_data [2];
    logic [1:0]      drv_valid;
    logic [1:0]      rdy, busy_v, done_v, ok_v;
    logic [1:0][1:0] err_v;
    logic [1:0][7:0] calc_v;
    logic [1:0][9:0] rx_v;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int ML = (g == 0) ? 1024 : 8;
        localparam int LW = (g == 0) ? 11 : 4;
        fix_frame_ctrl_if bus ();
        fix_frame_ctrl #(.MAX_LEN(ML), .LEN_W(LW)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
        assign bus.data_i  = drv_data[g];
        assign bus.valid_i = drv_valid[g];
        assign rdy[g]      = bus.ready_o;
        assign busy_v[g]   = bus.busy_o;
        assign done_v[g]   = bus.msg_done_o;
        assign ok_v[g]     = bus.msg_ok_o;
        assign err_v[g]    = bus.err_o;
        assign calc_v[g]   = bus.calc_cksum_o;
        assign rx_v[g]     = bus.rx_cksum_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: keeps the message text itself and derives results from it.
    logic [7:0] mbuf [2][1024];
    int  mlen [2], ndig [2], mrx [2], m_snap [2];
    int  m_err [2], m_calc [2], m_rx [2];
    bit  m_in [2], m_trl [2], m_rep [2];

    function automatic int maxlen(input int k);
        return (k == 0) ? 1024 : 8;
    endfunction

    task automatic m_report(input int k, input int e, input int c);
        m_rep[k]  = 1'b1;
        m_err[k]  = e;
        m_calc[k] = c;
        m_rx[k]   = mrx[k];
        m_in[k]   = 1'b0;
        m_trl[k]  = 1'b0;
        mlen[k]   = 0;
    endtask

    task automatic m_step(input int k, input logic [7:0] b);
        int s;
        if (!m_in[k]) begin
            if (b == 8'h38) begin
                m_in[k] = 1'b1; m_trl[k] = 1'b0; mbuf[k][0] = b; mlen[k] = 1;
            end
        end else if (m_trl[k]) begin
            if (ndig[k] < 3) begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    mrx[k] = mrx[k] * 10 + int'(b) - 48;
                    ndig[k]++;
                end else begin
                    m_report(k, 2, m_snap[k]);
                end
            end else begin
                m_report(k, (b != 8'h01) ? 2 : ((mrx[k] != m_snap[k]) ? 1 : 0), m_snap[k]);
            end
        end else if (mlen[k] + 1 > maxlen(k)) begin
            m_report(k, 3, 0);
        end else begin
            mbuf[k][mlen[k]] = b;
            mlen[k]++;
            if (mlen[k] == 2) begin
                if (b == 8'h38) mlen[k] = 1;
                else if (b != 8'h3D) begin m_in[k] = 1'b0; mlen[k] = 0; end
            end else if (mlen[k] >= 6 && b == 8'h3D && mbuf[k][mlen[k]-2] == 8'h30 &&
                         mbuf[k][mlen[k]-3] == 8'h31 && mbuf[k][mlen[k]-4] == 8'h01) begin
                s = 0;
                for (int i = 0; i <= mlen[k] - 4; i++) s += int'(mbuf[k][i]);
                m_snap[k] = s % 256;
                m_trl[k]  = 1'b1;
                ndig[k]   = 0;
                mrx[k]    = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_in[k] = 1'b0; m_trl[k] = 1'b0; m_rep[k] = 1'b0; mlen[k] = 0;
                m_err[k] = 0; m_calc[k] = 0; m_rx[k] = 0; mrx[k] = 0; ndig[k] = 0;
            end else if (m_rep[k]) begin
                m_rep[k] = 1'b0;
            end else if (drv_valid[k]) begin
                m_step(k, drv_data[k]);
            end
        end
    end

    int n_cmp, n_fail, cyc;
    int pin_req, pin_ack, pin_k, pin_kind, pin_err, pin_calc, pin_rx;
    int drv_to;
    bit fin_req, fin_done;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                chk("ready", k, int'(rdy[k]), int'(!m_rep[k]));
                chk("busy",  k, int'(busy_v[k]), int'(m_in[k] || m_rep[k]));
                chk("done",  k, int'(done_v[k]), int'(m_rep[k]));
                chk("calc",  k, int'(calc_v[k]), m_calc[k]);
                chk("rx",    k, int'(rx_v[k]), m_rx[k]);
                if (m_rep[k]) begin
                    chk("err", k, int'(err_v[k]), m_err[k]);
                    chk("ok",  k, int'(ok_v[k]), int'(m_err[k] == 0));
                end
            end
        end
        if (pin_req != pin_ack) begin
            if (pin_kind == 1) begin
                chk("pin_idle_busy", pin_k, int'(busy_v[pin_k]), 0);
                chk("pin_idle_done", pin_k, int'(done_v[pin_k]), 0);
                chk("pin_idle_calc", pin_k, int'(calc_v[pin_k]), 0);
                chk("pin_idle_rx",   pin_k, int'(rx_v[pin_k]), 0);
                pin_ack++;
            end else if (done_v[pin_k]) begin
                chk("pin_err",  pin_k, int'(err_v[pin_k]), pin_err);
                chk("pin_ok",   pin_k, int'(ok_v[pin_k]), int'(pin_err == 0));
                chk("pin_calc", pin_k, int'(calc_v[pin_k]), pin_calc);
                if (pin_rx >= 0) chk("pin_rx", pin_k, int'(rx_v[pin_k]), pin_rx);
                pin_ack++;
            end
        end
        if (fin_req && !fin_done) begin
            chk("drv_timeouts", 0, drv_to, 0);
            chk("pins_pending", 0, pin_ack, pin_req);
            fin_done = 1'b1;
        end
    end

    logic [7:0] fb [256];
    int fl;
    bit rnd_gap;

    task automatic add_b(input logic [7:0] b);
        fb[fl] = b;
        fl++;
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) add_b(s[i]);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input int gap);
        int guard;
        drv_data[k]  = b;
        drv_valid[k] = 1'b1;
        guard = 0;
        while (!rdy[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[k]) begin
            drv_to++;
            $display("FAIL drv_ready[%0d]: ready stuck low, got 0 expected 1", k);
        end
        @(negedge clk);
        drv_valid[k] = 1'b0;
        if (gap > 0) repeat (gap) @(negedge clk);
        else if (rnd_gap && $urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 2))) @(negedge clk);
    endtask

    task automatic send_buf(input int k, input int gap);
        for (int i = 0; i < fl; i++) send_byte(k, fb[i], gap);
        fl = 0;
    endtask

    task automatic wait_pin();
        for (int i = 0; i < 100 && pin_ack != pin_req; i++) @(negedge clk);
    endtask

    task automatic pin(input int k, input int kind, input int e, input int c, input int r);
        wait_pin();
        pin_k = k; pin_kind = kind; pin_err = e; pin_calc = c; pin_rx = r;
        pin_req++;
    endtask

    task automatic min_frame(input string trl);
        add_str("8=A"); add_b(8'h01); add_str(trl); add_b(8'h01);
    endtask

    initial begin
        int k, kind, nf, v, s, gl, nc;
        logic [7:0] dg [3];
        rst = 1'b1; drv_valid = '0; drv_data[0] = '0; drv_data[1] = '0;
        fl = 0; rnd_gap = 1'b0; drv_to = 0; pin_req = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        pin(0, 0, 0, 183, 183);  min_frame("10=183"); send_buf(0, 0);
        pin(0, 0, 1, 183, 184);  min_frame("10=184"); send_buf(0, 0);
        pin(0, 0, 0, 153, 153);
        add_str("8=A"); add_b(8'h01); add_str("11=B"); add_b(8'h01); add_str("10=153"); add_b(8'h01);
        send_buf(0, 0);
        pin(0, 0, 2, 183, 1);    add_str("8=A"); add_b(8'h01); add_str("10=1x"); send_buf(0, 0);
        pin(0, 0, 0, 183, 183);  min_frame("10=183"); send_buf(0, 0);
        pin(1, 0, 3, 0, -1);     add_str("8=ABCDEFGZZ"); send_buf(1, 0);
        pin(1, 0, 0, 183, 183);  min_frame("10=183"); send_buf(1, 0);
        pin(0, 0, 0, 183, 183);  min_frame("10=183"); send_buf(0, 1);
        wait_pin();
        add_str("8=AB"); send_buf(0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pin(0, 1, 0, 0, 0);
        wait_pin();

        rnd_gap = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 5));
            fl = 0;
            if (kind == 5) begin
                gl = int'($urandom_range(1, 6));
                for (int i = 0; i < gl; i++) begin
                    case ($urandom_range(0, 5))
                        0: add_b(8'h38);
                        1: add_b(8'h3D);
                        2: add_b(8'h01);
                        3: add_b(8'h31);
                        4: add_b(8'h30);
                        default: add_b(8'($urandom_range(0, 255)));
                    endcase
                end
            end else begin
                add_str("8=");
                nf = (k == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(1, 5));
                if (nf == 0) add_b(8'h01);
                for (int f = 0; f < nf; f++) begin
                    add_b(8'(48 + $urandom_range(1, 9)));
                    add_b(8'(48 + $urandom_range(0, 9)));
                    add_b(8'h3D);
                    nc = int'($urandom_range(0, 4));
                    for (int c = 0; c < nc; c++) begin
                        case ($urandom_range(0, 3))
                            0: add_b(8'(65 + $urandom_range(0, 25)));
                            1: add_b(8'(48 + $urandom_range(0, 9)));
                            2: add_str("10=");
                            default: add_b(8'h3D);
                        endcase
                    end
                    add_b(8'h01);
                end
                s = 0;
                for (int i = 0; i < fl; i++) s += int'(fb[i]);
                s = s % 256;
                v = (kind == 1) ? (s + int'($urandom_range(1, 998))) % 1000 : s;
                dg[0] = 8'(48 + v / 100);
                dg[1] = 8'(48 + (v / 10) % 10);
                dg[2] = 8'(48 + v % 10);
                if (kind == 2) dg[$urandom_range(0, 2)] = 8'h78;
                add_str("10=");
                add_b(dg[0]); add_b(dg[1]); add_b(dg[2]);
                add_b((kind == 3) ? 8'h5A : 8'h01);
            end
            send_buf(k, 0);
        end

        repeat (4) @(negedge clk);
        wait_pin();
        fin_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
